// File: rtl/counter_sync_param.sv
// Parametrised up/down modulo counter with parallel load, enable, terminal count and wrap pulse.
// Latency: count/count_o/wrap update one clk edge after inputs are sampled; tc is combinational.
// Backpressure: none; en gates counting and load overrides en. Macro COUNTER_SAT_EN selects saturation.
module counter_sync_param #(
    parameter int WIDTH   = 3,
    parameter int MODULO  = 8,
    parameter int INV_OUT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_o,
    output logic             tc,
    output logic             wrap
);

    // MODULO may equal 2**WIDTH, so the range check needs one extra bit.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULO);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

`ifdef COUNTER_SAT_EN
    // Saturating: the end values are sticky in their own direction.
    localparam logic [WIDTH-1:0] UP_END_NXT = MAX_VAL;
    localparam logic [WIDTH-1:0] DN_END_NXT = '0;
`else
    // Wrap-around: leaving one end re-enters at the other.
    localparam logic [WIDTH-1:0] UP_END_NXT = '0;
    localparam logic [WIDTH-1:0] DN_END_NXT = MAX_VAL;
`endif

    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;

    assign at_max  = (count == MAX_VAL);
    assign at_zero = (count == '0);

    // Out-of-range load values are pinned to the top of the count range.
    assign load_clamped = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;

    // Terminal count is masked while loading or idle.
    assign tc = en & ~load & (up_dn ? at_max : at_zero);

    // Next-state selection in priority order load > en > hold.
    always_comb begin
        count_nxt = count;
        if (load) begin
            count_nxt = load_clamped;
        end else if (en) begin
            if (up_dn) begin
                count_nxt = at_max ? UP_END_NXT : count + 1'b1;
            end else begin
                count_nxt = at_zero ? DN_END_NXT : count - 1'b1;
            end
        end
    end

`ifdef COUNTER_SAT_EN
    // No wrap ever happens in saturating mode.
    assign wrap_nxt = 1'b0;
`else
    // A terminal count on this edge is exactly a wrap.
    assign wrap_nxt = tc;
`endif

    // State register; rst clears everything immediately, without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_nxt;
            wrap  <= wrap_nxt;
        end
    end

    // Output bus polarity fixed at elaboration.
    generate
        if (INV_OUT != 0) begin : g_inv
            assign count_o = ~count;
        end else begin : g_true
            assign count_o = count;
        end
    endgenerate

endmodule
